sockit_spi_cdc_fifo: RTL and testbench
======================================

Name: sockit_spi_cdc_fifo

Overview:
Parametrised dual-clock FIFO that carries SPI command and data words between the bus-side clock domain (cdi_*) and the SPI serializer clock domain (cdo_*).
- Gray-coded pointers with a configurable synchronizer depth.
- Explicit full/empty detection using an extra wrap bit.
- Per-side fill-level reporting and a per-side synchronous clear.
- Drop-in successor of the single-counter CDC; used for both command and read-data paths.

Parameters:
DW, 8, data width in bits
AW, 2, address width; FIFO depth = 2**AW words
SS, 2, synchronizer stages per crossing direction (legal values 2..4)

Ports:
cdi_clk  input  1  input-side clock
cdi_rst  input  1  input-side reset, asynchronous, active-high
cdi_clr  input  1  input-side synchronous clear
cdi_dat  input  DW  write data
cdi_vld  input  1  write valid
cdi_rdy  output  1  write ready (not full)
cdi_lvl  output  AW+1  input-side fill level, 0..2**AW
cdo_clk  input  1  output-side clock
cdo_rst  input  1  output-side reset, asynchronous, active-high
cdo_clr  input  1  output-side synchronous clear
cdo_dat  output  DW  read data
cdo_vld  output  1  read valid (not empty)
cdo_rdy  input  1  read ready
cdo_lvl  output  AW+1  output-side fill level, 0..2**AW

Behaviour:
Pointers:
- Write pointer wp and read pointer rp are (AW+1)-bit binary counters, stored and crossed as Gray code.
- The MSB is the wrap bit.
- Increment is modulo 2**(AW+1).
Synchronizers:
- rp_s is rp passed through an SS-deep flop chain clocked by cdi_clk.
- wp_s is wp passed through an SS-deep flop chain clocked by cdo_clk.
- Only Gray values cross domains; no other signal crosses.
Memory:
- 2**AW x DW register array, written on cdi_clk at index wp[AW-1:0].
- Read asynchronously at index rp[AW-1:0].
Input side:
- cdi_lvl = bin(wp) - bin(rp_s), modulo 2**(AW+1).
- cdi_rdy = (cdi_lvl != 2**AW) & ~cdi_clr. This is combinational from registers and cdi_clr; it does not depend on cdi_vld.
- A write occurs on a cdi_clk edge when cdi_vld & cdi_rdy: mem[wp] <= cdi_dat, then wp increments.
Output side:
- cdo_lvl = bin(wp_s) - bin(rp).
- cdo_vld = (cdo_lvl != 0) & ~cdo_clr.
- cdo_dat = mem[rp[AW-1:0]], valid only while cdo_vld is high.
- A read occurs when cdo_vld & cdo_rdy; rp then increments.
Latency:
- A write at cdi_clk edge N makes cdo_vld rise after exactly SS cdo_clk rising edges, with an additional 0..1 cdo_clk of metastability uncertainty.
- Freed space becomes visible on cdi_rdy after SS cdi_clk edges, same uncertainty.
Clear:
- cdi_clr high at an edge: wp <= rp_s. Any pending write is suppressed because cdi_rdy is forced low.
- cdo_clr high at an edge: rp <= wp_s. Any pending read is suppressed.
- Clear discards all words visible to that side. Words written by the opposite side but not yet synchronized survive.
Boundaries:
- Full: cdi_lvl = 2**AW, cdi_rdy = 0. cdi_vld is ignored; memory and wp are unchanged.
- Empty: cdo_vld = 0. cdo_rdy is ignored.
- Wrap: the pointer passes from 2**(AW+1)-1 to 0 with no gap in data order.
- Simultaneous read and write in a full or empty state: each side acts only on its own synchronized view. This is conservative; no overflow or underflow is possible.
Reset:
- cdi_rst clears wp and the rp_s chain. Resulting outputs: cdi_rdy = 1, cdi_lvl = 0.
- cdo_rst clears rp and the wp_s chain. Resulting outputs: cdo_vld = 0, cdo_lvl = 0.
- Both resets shall be asserted together, overlapping by at least SS cycles of the slower clock.
- Single-side reset mid-operation is illegal; use cdi_clr or cdo_clr instead. The bench flags a single-side reset as a protocol error.
- Memory contents are not reset.

Optional Feature:
SOCKIT_SPI_CDC_OREG_EN: registered output stage.
- Defined: a one-word skid register sits after the memory read.
  - cdo_dat and cdo_vld come directly from flops.
  - The register loads when it is empty or is being consumed, and memory is non-empty.
  - Write-to-cdo_vld latency becomes SS+1 cdo_clk edges.
  - cdo_lvl includes the registered word.
  - cdo_clr also empties the register.
  - Effective capacity becomes 2**AW+1.
- Undefined: asynchronous read path exactly as described above.

Test Plan:
1. Reset, DW=8 AW=2 SS=2: write 0x11,0x22,0x33,0x44 back-to-back with cdo_rdy=0 -> cdi_rdy low after 4th write, cdi_lvl=4. Fifth word 0x55 is held, not written.
2. From test 1 state, cdo_rdy=1 -> cdo_dat sequence 0x11,0x22,0x33,0x44. cdo_vld falls after the 4th read; cdo_lvl=0.
3. Single write 0xA5 with cdo_clk 3x faster than cdi_clk -> cdo_vld rises within 2-3 cdo_clk edges of the write edge; 0xA5 is read exactly once.
4. Continuous streaming of 20 incrementing words, 0x00..0x13, with random vld/rdy throttling and unrelated clocks (7 ns / 11 ns) -> all 20 words received in order, passing through at least 2 pointer wraps, no duplicates.
5. Write 3 words, wait 4 cdo_clk, pulse cdo_clr -> cdo_vld=0 and cdo_lvl=0 next cycle. cdi_lvl returns to 0 within SS+1 cdi_clk. A subsequent write of 0x77 reads back as 0x77.
6. cdi_clr asserted in the same cycle as cdi_vld=1 with cdi_dat=0x99 -> cdi_rdy=0 in that cycle, 0x99 is never delivered, wp equals rp_s afterwards.

Source files
------------

// File: rtl/sockit_spi_cdc_fifo.sv
// Dual-clock FIFO for SPI command/data words. Gray pointers with an extra wrap bit cross through SS-deep synchronizers.
// The optional registered output stage is enabled with `define SOCKIT_SPI_CDC_OREG_EN.
module sockit_spi_cdc_fifo #(
   parameter int DW = 8,
   parameter int AW = 2,
   parameter int SS = 2
)(
   input  logic          cdi_clk,
   input  logic          cdi_rst,
   input  logic          cdi_clr,
   input  logic [DW-1:0] cdi_dat,
   input  logic          cdi_vld,
   output logic          cdi_rdy,
   output logic [AW:0]   cdi_lvl,
   input  logic          cdo_clk,
   input  logic          cdo_rst,
   input  logic          cdo_clr,
   output logic [DW-1:0] cdo_dat,
   output logic          cdo_vld,
   input  logic          cdo_rdy,
   output logic [AW:0]   cdo_lvl
);

   localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};

   function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
      logic [AW:0] b;
      b[AW] = g[AW];
      for (int i = AW-1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   logic [DW-1:0] mem [2**AW];

   logic [AW:0] wp_bin, wp_gry, wp_nxt;
   logic [AW:0] rp_bin, rp_gry, rp_nxt;
   logic [AW:0] rp_sync [SS];
   logic [AW:0] wp_sync [SS];
   logic [AW:0] rp_s_bin, wp_s_bin, mem_lvl;
   logic        wr_en, rd_en;

   // ---------------- input side ----------------
   assign rp_s_bin = gray2bin(rp_sync[SS-1]);
   assign cdi_lvl  = wp_bin - rp_s_bin;
   assign cdi_rdy  = (cdi_lvl != FULL) & ~cdi_clr;
   assign wr_en    = cdi_vld & cdi_rdy;
   assign wp_nxt   = wp_bin + 1'b1;

   always_ff @(posedge cdi_clk or posedge cdi_rst) begin
      if (cdi_rst) begin
         wp_bin <= '0;
         wp_gry <= '0;
      end else if (cdi_clr) begin
         wp_bin <= rp_s_bin;
         wp_gry <= rp_sync[SS-1];
      end else if (wr_en) begin
         wp_bin <= wp_nxt;
         wp_gry <= bin2gray(wp_nxt);
      end
   end

   always_ff @(posedge cdi_clk or posedge cdi_rst) begin
      if (cdi_rst) begin
         for (int i = 0; i < SS; i++) rp_sync[i] <= '0;
      end else begin
         rp_sync[0] <= rp_gry;
         for (int i = 1; i < SS; i++) rp_sync[i] <= rp_sync[i-1];
      end
   end

   // storage is deliberately not reset
   always_ff @(posedge cdi_clk) begin
      if (wr_en) mem[wp_bin[AW-1:0]] <= cdi_dat;
   end

   // ---------------- output side ----------------
   assign wp_s_bin = gray2bin(wp_sync[SS-1]);
   assign mem_lvl  = wp_s_bin - rp_bin;
   assign rp_nxt   = rp_bin + 1'b1;

   always_ff @(posedge cdo_clk or posedge cdo_rst) begin
      if (cdo_rst) begin
         for (int i = 0; i < SS; i++) wp_sync[i] <= '0;
      end else begin
         wp_sync[0] <= wp_gry;
         for (int i = 1; i < SS; i++) wp_sync[i] <= wp_sync[i-1];
      end
   end

   always_ff @(posedge cdo_clk or posedge cdo_rst) begin
      if (cdo_rst) begin
         rp_bin <= '0;
         rp_gry <= '0;
      end else if (cdo_clr) begin
         rp_bin <= wp_s_bin;
         rp_gry <= wp_sync[SS-1];
      end else if (rd_en) begin
         rp_bin <= rp_nxt;
         rp_gry <= bin2gray(rp_nxt);
      end
   end

`ifdef SOCKIT_SPI_CDC_OREG_EN
   logic [DW-1:0] oreg_dat;
   logic          oreg_vld;

   // refill the skid word when it is empty or leaving this cycle
   assign rd_en = (mem_lvl != '0) & (~oreg_vld | cdo_rdy) & ~cdo_clr;

   always_ff @(posedge cdo_clk or posedge cdo_rst) begin
      if (cdo_rst) begin
         oreg_vld <= 1'b0;
         oreg_dat <= '0;
      end else if (cdo_clr) begin
         oreg_vld <= 1'b0;
      end else if (rd_en) begin
         oreg_vld <= 1'b1;
         oreg_dat <= mem[rp_bin[AW-1:0]];
      end else if (cdo_rdy) begin
         oreg_vld <= 1'b0;
      end
   end

   assign cdo_vld = oreg_vld;
   assign cdo_dat = oreg_dat;
   assign cdo_lvl = mem_lvl + {{AW{1'b0}}, oreg_vld};
`else
   assign cdo_vld = (mem_lvl != '0) & ~cdo_clr;
   assign rd_en   = cdo_vld & cdo_rdy;
   assign cdo_dat = mem[rp_bin[AW-1:0]];
   assign cdo_lvl = mem_lvl;
`endif

endmodule

// File: tb/tb_sockit_spi_cdc_fifo.sv
// Self-checking bench for sockit_spi_cdc_fifo: a word queue models the FIFO, directed phases follow the test plan.
`timescale 1ns/1ps
module tb_sockit_spi_cdc_fifo;
   localparam int DW = 8;
   localparam int AW = 2;
   localparam int SS = 2;

   logic          cdi_clk = 1'b0, cdo_clk = 1'b0;
   logic          cdi_rst = 1'b1, cdo_rst = 1'b1;
   logic          cdi_clr = 1'b0, cdo_clr = 1'b0;
   logic          cdi_vld = 1'b0, cdo_rdy = 1'b0;
   logic [DW-1:0] cdi_dat = '0;
   logic [DW-1:0] cdo_dat;
   logic          cdi_rdy, cdo_vld;
   logic [AW:0]   cdi_lvl, cdo_lvl;

   real cdi_half = 5.0;
   real cdo_half = 7.0;

   always #(cdi_half) cdi_clk = ~cdi_clk;
   always #(cdo_half) cdo_clk = ~cdo_clk;

   sockit_spi_cdc_fifo #(.DW(DW), .AW(AW), .SS(SS)) dut (
      .cdi_clk(cdi_clk), .cdi_rst(cdi_rst), .cdi_clr(cdi_clr), .cdi_dat(cdi_dat),
      .cdi_vld(cdi_vld), .cdi_rdy(cdi_rdy), .cdi_lvl(cdi_lvl),
      .cdo_clk(cdo_clk), .cdo_rst(cdo_rst), .cdo_clr(cdo_clr), .cdo_dat(cdo_dat),
      .cdo_vld(cdo_vld), .cdo_rdy(cdo_rdy), .cdo_lvl(cdo_lvl)
   );

   int n_cmp = 0;
   int n_bad = 0;
   logic [DW-1:0] model_q [$];
   logic [DW-1:0] rd_log  [$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic cdi_step();
      @(posedge cdi_clk);
      #1;
   endtask

   task automatic cdo_step();
      @(posedge cdo_clk);
      #1;
   endtask

   // writer-side model: accepted words enter the queue, a clear drops what the writer still counts
   always @(negedge cdi_clk) begin
      if (cdi_rst !== cdo_rst) chk("rst_pair", {31'b0, cdi_rst}, {31'b0, cdo_rst});
      if (!cdi_rst) begin
         if (cdi_clr) begin
            for (int i = 0; i < int'(cdi_lvl) && model_q.size() > 0; i++) void'(model_q.pop_back());
         end else if (cdi_vld && cdi_rdy) begin
            model_q.push_back(cdi_dat);
         end
      end
   end

   always @(negedge cdo_clk) begin
      if (!cdo_rst) begin
         if (cdo_clr) begin
            for (int i = 0; i < int'(cdo_lvl) && model_q.size() > 0; i++) void'(model_q.pop_front());
         end else if (cdo_vld && cdo_rdy) begin
            if (model_q.size() == 0) chk("rd_underflow", {31'b0, cdo_vld}, 32'd0);
            else chk("rd_dat", {24'b0, cdo_dat}, {24'b0, model_q.pop_front()});
            rd_log.push_back(cdo_dat);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int n;
      #103;
      cdi_rst = 1'b0;
      cdo_rst = 1'b0;
      repeat (3) cdi_step();
      chk("rst_cdi_rdy", {31'b0, cdi_rdy}, 32'd1);
      chk("rst_cdi_lvl", {29'b0, cdi_lvl}, 32'd0);
      chk("rst_cdo_vld", {31'b0, cdo_vld}, 32'd0);
      chk("rst_cdo_lvl", {29'b0, cdo_lvl}, 32'd0);

      // fill to full, fifth word must be held off
      cdi_step();
      cdi_vld = 1'b1; cdi_dat = 8'h11;
      cdi_step(); cdi_dat = 8'h22;
      cdi_step(); cdi_dat = 8'h33;
      cdi_step(); cdi_dat = 8'h44;
      cdi_step(); cdi_dat = 8'h55;
      chk("t1_rdy_full", {31'b0, cdi_rdy}, 32'd0);
      chk("t1_lvl_full", {29'b0, cdi_lvl}, 32'd4);
      repeat (5) cdi_step();
      chk("t1_lvl_hold", {29'b0, cdi_lvl}, 32'd4);
      chk("t1_rdy_hold", {31'b0, cdi_rdy}, 32'd0);
      chk("t1_model_sz", model_q.size(), 32'd4);
      cdi_vld = 1'b0;
      repeat (6) cdo_step();
      chk("t1_cdo_lvl", {29'b0, cdo_lvl}, 32'd4);
      chk("t1_cdo_vld", {31'b0, cdo_vld}, 32'd1);
      chk("t1_cdo_dat", {24'b0, cdo_dat}, 32'h11);

      // drain
      base = rd_log.size();
      cdo_rdy = 1'b1;
      for (int i = 0; i < 40 && cdo_vld; i++) cdo_step();
      cdo_rdy = 1'b0;
      chk("t2_vld_low", {31'b0, cdo_vld}, 32'd0);
      chk("t2_cdo_lvl", {29'b0, cdo_lvl}, 32'd0);
      chk("t2_cnt", rd_log.size() - base, 32'd4);
      for (int i = 0; i < 4 && base + i < rd_log.size(); i++)
         chk("t2_seq", {24'b0, rd_log[base+i]}, 32'h11 * (i + 1));
      repeat (6) cdi_step();
      chk("t2_cdi_lvl", {29'b0, cdi_lvl}, 32'd0);
      chk("t2_cdi_rdy", {31'b0, cdi_rdy}, 32'd1);

      // latency with a 3x faster reader
      cdi_half = 15.0;
      cdo_half = 5.0;
      repeat (4) cdi_step();
      base = rd_log.size();
      cdi_vld = 1'b1; cdi_dat = 8'hA5;
      @(posedge cdi_clk);
      #1 cdi_vld = 1'b0;
      n = 0;
      while (!cdo_vld && n < 10) begin
         @(posedge cdo_clk);
         #1;
         n++;
      end
      chk("t3_vld", {31'b0, cdo_vld}, 32'd1);
      chk("t3_lat_ok", {31'b0, (n >= SS && n <= SS + 1)}, 32'd1);
      cdo_rdy = 1'b1;
      repeat (20) cdo_step();
      cdo_rdy = 1'b0;
      chk("t3_cnt", rd_log.size() - base, 32'd1);
      if (rd_log.size() > base) chk("t3_dat", {24'b0, rd_log[base]}, 32'hA5);
      chk("t3_vld_low", {31'b0, cdo_vld}, 32'd0);

      // random-throttled stream across unrelated clocks
      cdi_half = 3.5;
      cdo_half = 5.5;
      repeat (4) cdi_step();
      base = rd_log.size();
      fork
         begin
            int idx = 0;
            int guard = 0;
            while (idx < 20 && guard < 4000) begin
               cdi_step();
               cdi_dat = DW'(idx);
               cdi_vld = ($urandom_range(0, 3) != 0);
               @(negedge cdi_clk);
               if (cdi_vld && cdi_rdy) idx++;
               guard++;
            end
            cdi_step();
            cdi_vld = 1'b0;
         end
         begin
            int guard = 0;
            while (rd_log.size() < base + 20 && guard < 4000) begin
               cdo_step();
               cdo_rdy = ($urandom_range(0, 2) != 0);
               guard++;
            end
            cdo_rdy = 1'b0;
         end
      join
      chk("t4_cnt", rd_log.size() - base, 32'd20);
      for (int i = 0; i < 20 && base + i < rd_log.size(); i++)
         chk("t4_ord", {24'b0, rd_log[base+i]}, i);

      // output-side clear
      cdi_half = 5.0;
      cdo_half = 7.0;
      repeat (6) cdi_step();
      cdi_vld = 1'b1; cdi_dat = 8'h61;
      cdi_step(); cdi_dat = 8'h62;
      cdi_step(); cdi_dat = 8'h63;
      cdi_step(); cdi_vld = 1'b0;
      repeat (4) cdo_step();
      chk("t5_pre_lvl", {29'b0, cdo_lvl}, 32'd3);
      cdo_clr = 1'b1;
      #1 chk("t5_vld_clr", {31'b0, cdo_vld}, 32'd0);
      cdo_step();
      cdo_clr = 1'b0;
      #1;
      chk("t5_vld", {31'b0, cdo_vld}, 32'd0);
      chk("t5_lvl", {29'b0, cdo_lvl}, 32'd0);
      repeat (SS + 1) cdi_step();
      chk("t5_cdi_lvl", {29'b0, cdi_lvl}, 32'd0);
      chk("t5_model_sz", model_q.size(), 32'd0);
      cdi_vld = 1'b1; cdi_dat = 8'h77;
      cdi_step(); cdi_vld = 1'b0;
      base = rd_log.size();
      cdo_rdy = 1'b1;
      repeat (10) cdo_step();
      cdo_rdy = 1'b0;
      chk("t5_cnt", rd_log.size() - base, 32'd1);
      if (rd_log.size() > base) chk("t5_dat", {24'b0, rd_log[base]}, 32'h77);

      // input-side clear colliding with a write
      repeat (4) cdi_step();
      base = rd_log.size();
      cdi_vld = 1'b1; cdi_dat = 8'h99; cdi_clr = 1'b1;
      #1 chk("t6_rdy_clr", {31'b0, cdi_rdy}, 32'd0);
      cdi_step();
      cdi_clr = 1'b0; cdi_vld = 1'b0;
      #1;
      chk("t6_lvl", {29'b0, cdi_lvl}, 32'd0);
      chk("t6_rdy", {31'b0, cdi_rdy}, 32'd1);
      cdo_rdy = 1'b1;
      repeat (10) cdo_step();
      cdo_rdy = 1'b0;
      chk("t6_no_read", rd_log.size() - base, 32'd0);
      chk("t6_vld", {31'b0, cdo_vld}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
